ram_fifo_ctrl: RTL and testbench

//  Stream-side controller that turns single_port_sync_ram into a FIFO. Accepts a valid/ready write

---
 rtl/ram_fifo_ctrl_if.sv | 26 ++
 rtl/ram_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Stream-side bundle of ram_fifo_ctrl: write stream, read stream and occupancy status.
// The master is the producer/consumer environment, and the slave is the FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 24
) ();
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count, full, empty
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count, full, empty
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that uses a single-port synchronous RAM as a circular buffer.
// A one-word output register presents the oldest word on a valid/ready read stream.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_fifo_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic {
        IDLE,
        RD_CAP
    } state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q,   mem_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

    logic fetch;
    logic wr_ready;
    logic wr_fire;
    logic rd_fire;
    logic drive_wr;

    // A fetch owns the single RAM port, so it blocks writes for that cycle.
    assign fetch    = (state_q == IDLE) && !out_valid_q && (mem_cnt_q != '0);
    assign wr_ready = rst_n && (state_q == IDLE) && !fetch && (mem_cnt_q < DEPTH_C);
    assign wr_fire  = bus.wr_valid && wr_ready;
    assign rd_fire  = out_valid_q && bus.rd_ready;

    assign ram_data = drive_wr ? bus.wr_data : {DATA_WIDTH{1'bz}};

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = out_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.count    = mem_cnt_q + (ADDR_WIDTH+1)'(out_valid_q);
    assign bus.full     = (mem_cnt_q == DEPTH_C);
    assign bus.empty    = (mem_cnt_q == '0) && !out_valid_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        out_valid_d = out_valid_q;
        rd_data_d   = rd_data_q;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_addr    = rd_ptr_q;
        drive_wr    = 1'b0;

        if (rd_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fetch) begin
                    ram_cs  = 1'b1;
                    state_d = RD_CAP;
                end else if (wr_fire) begin
                    ram_cs    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = wr_ptr_q;
                    drive_wr  = 1'b1;
                    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
                    mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(1);
                end
            end
            RD_CAP: begin
                ram_cs      = 1'b1;
                ram_oe      = 1'b1;
                rd_data_d   = ram_data;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
                mem_cnt_d   = mem_cnt_q - (ADDR_WIDTH+1)'(1);
                state_d     = IDLE;
            end
        endcase

        // The RAM bus is idle and released for as long as reset is held.
        if (!rst_n) begin
            ram_cs   = 1'b0;
            ram_we   = 1'b0;
            ram_oe   = 1'b0;
            drive_wr = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: RAM contents are never cleared; zeroed pointers and count make them stale.
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural synchronous RAM and a queue-based FIFO model.
// The bench combines directed cycle tables, fill/drain, random traffic and reset during a capture.
module tb_ram_fifo_ctrl;

    localparam int AW = 5;
    localparam int DW = 24;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    int errors = 0;
    int checks = 0;

    ram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: write or registered read on cs, output drive on oe.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_data;
            else        ram_q <= ram_mem[ram_addr];
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO content is a queue of accepted words in arrival order.
    logic [DW-1:0] model_q [$];
    int unsigned   wr_total = 0;
    bit            saw_wrap = 0;
    bit            have_last = 0;
    logic [AW-1:0] last_wr_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            wr_total  = 0;
            have_last = 0;
        end else begin
            check("count", bus.count, model_q.size());
            check("empty", bus.empty, model_q.size() == 0);
            if (model_q.size() == DEPTH + 1) begin
                check("full_at_capacity", bus.full, 1);
                check("wr_ready_at_capacity", bus.wr_ready, 0);
            end else if (model_q.size() < DEPTH) begin
                check("not_full", bus.full, 0);
            end
            if (ram_cs) begin
                check("no_contention", ram_we && ram_oe, 0);
                if (ram_we || ram_oe) check("ram_data_known", $isunknown(ram_data), 0);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (model_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_on_empty: got rd_valid=1 expected no word held at %0t", $time);
                end else begin
                    check("rd_data_order", bus.rd_data, model_q.pop_front());
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                check("wr_addr", ram_addr, wr_total % DEPTH);
                check("wr_strobes", {ram_cs, ram_we, ram_oe}, 3'b110);
                check("wr_bus_data", ram_data, bus.wr_data);
                if (have_last && last_wr_addr == AW'(DEPTH - 1) && ram_addr == '0) saw_wrap = 1;
                last_wr_addr = ram_addr;
                have_last    = 1;
                model_q.push_back(bus.wr_data);
                wr_total++;
            end
        end
    end

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_wr_ready;
        logic          e_rd_valid;
        logic [DW-1:0] e_rd_data;
        logic [AW:0]   e_count;
        logic          e_cs;
        logic          e_we;
        logic          e_oe;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vt [14];

    task automatic send(input logic [DW-1:0] d, input int max_cyc, output bit ok);
        bit acc;
        ok = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            acc = bus.wr_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int n_acc;
        int got;
        int last_c;
        bit found;
        logic [DW-1:0] zz;

        zz = {DW{1'bz}};
        //          wv  wd          rr   wrdy rv  rd_data     cnt  cs  we  oe  addr  ram_data
        vt[0]  = '{1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 24'h000000, 6'd0, 1'b1, 1'b1, 1'b0, 5'd0, 24'hABCDEF};
        vt[1]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b0, 5'd0, zz};
        vt[2]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b1, 5'd0, 24'hABCDEF};
        vt[3]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'hABCDEF, 6'd1, 1'b0, 1'b0, 1'b0, 5'd1, zz};
        vt[4]  = '{1'b1, 24'h123456, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 6'd1, 1'b1, 1'b1, 1'b0, 5'd1, 24'h123456};
        vt[5]  = '{1'b1, 24'h777777, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b0, 5'd1, zz};
        vt[6]  = '{1'b1, 24'h777777, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b1, 5'd1, 24'h123456};
        vt[7]  = '{1'b1, 24'h777777, 1'b0, 1'b1, 1'b1, 24'h123456, 6'd1, 1'b1, 1'b1, 1'b0, 5'd2, 24'h777777};
        vt[8]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h123456, 6'd2, 1'b0, 1'b0, 1'b0, 5'd2, zz};
        vt[9]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 24'h123456, 6'd2, 1'b0, 1'b0, 1'b0, 5'd2, zz};
        vt[10] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b0, 5'd2, zz};
        vt[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 24'h000000, 6'd1, 1'b1, 1'b0, 1'b1, 5'd2, 24'h777777};
        vt[12] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 24'h777777, 6'd1, 1'b0, 1'b0, 1'b0, 5'd3, zz};
        vt[13] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b0, 1'b0, 5'd3, zz};

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_ram_cs", ram_cs, 0);
        check("rst_ram_data_z", ram_data, zz);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single write latency, write blocked by a pending fetch, interleaved read/write.
        for (int i = 0; i < 14; i++) begin
            bus.wr_valid = vt[i].wv;
            bus.wr_data  = vt[i].wd;
            bus.rd_ready = vt[i].rr;
            @(negedge clk);
            check($sformatf("vec%0d_wr_ready", i), bus.wr_ready, vt[i].e_wr_ready);
            check($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vt[i].e_rd_valid);
            if (vt[i].e_rd_valid) check($sformatf("vec%0d_rd_data", i), bus.rd_data, vt[i].e_rd_data);
            check($sformatf("vec%0d_count", i), bus.count, vt[i].e_count);
            check($sformatf("vec%0d_ram_ctl", i), {ram_cs, ram_we, ram_oe},
                  {vt[i].e_cs, vt[i].e_we, vt[i].e_oe});
            check($sformatf("vec%0d_ram_addr", i), ram_addr, vt[i].e_addr);
            check($sformatf("vec%0d_ram_data", i), ram_data, vt[i].e_data);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;

        // Fill to capacity DEPTH+1, then one refused word.
        n_acc = 0;
        for (int w = 1; w <= DEPTH + 1; w++) begin
            send(DW'(w), 10, ok);
            if (ok) n_acc++;
        end
        check("fill_accepted", n_acc, DEPTH + 1);
        send(DW'(DEPTH + 2), 20, ok);
        check("fill_overflow_refused", ok, 0);
        @(negedge clk);
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, DEPTH + 1);
        check("fill_wr_ready", bus.wr_ready, 0);
        @(posedge clk);
        #1;

        // Drain: words come out in order, one every three cycles.
        bus.rd_ready = 1'b1;
        got = 0;
        last_c = 0;
        for (int c = 0; c < 300 && got < DEPTH + 1; c++) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                check("drain_order", bus.rd_data, got + 1);
                if (got > 0) check("drain_interval", c - last_c, 3);
                last_c = c;
                got++;
            end
        end
        check("drain_all_words", got, DEPTH + 1);
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", bus.empty, 1);
        @(posedge clk);
        #1;

        // Random interleaved traffic; the monitor compares against the queue model.
        for (int c = 0; c < 500; c++) begin
            bus.wr_valid = ($urandom_range(0, 9) < 6);
            bus.wr_data  = DW'($urandom);
            bus.rd_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.empty) begin
                found = 1;
                break;
            end
        end
        check("random_drained", found, 1);
        check("random_write_volume", wr_total >= 40, 1);
        check("addr_wrapped", saw_wrap, 1);
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;

        // Reset during a capture with five words held.
        for (int w = 0; w < 6; w++) begin
            send(24'hC00000 + DW'(w), 10, ok);
        end
        repeat (4) @(posedge clk);
        #1;
        bus.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ram_oe) begin
                found = 1;
                break;
            end
        end
        check("capture_reached", found, 1);
        check("capture_held", bus.count, 5);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_count", bus.count, 0);
        check("abort_rd_valid", bus.rd_valid, 0);
        check("abort_ram_cs", ram_cs, 0);
        check("abort_ram_data_z", ram_data, zz);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_cs", ram_cs, 0);
        check("abort_idle_wr_ready", bus.wr_ready, 1);
        check("abort_idle_empty", bus.empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
